// File: rtl/alu_pkg.sv
// Shared ALU type definitions.
// alu_op_t is the operation selector of the combinational alu and of its requesters.
package alu_pkg;

    typedef enum logic [3:0] {
        AluAdd,
        AluSub,
        AluSll,
        AluSlt,
        AluSltu,
        AluXor,
        AluSrl,
        AluSra,
        AluOr,
        AluAnd
    } alu_op_t;

endpackage

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational alu between NUM_REQ requesters.
// The granted request drives the alu. The alu result is captured into a one-entry response
// buffer and returned to the requester that issued it.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  per-requester request handshake (req_ready is one-hot or zero)
//   req_a/req_b/req_op   per-requester operands and operation
//   alu_a/alu_b/alu_op   drive to the shared alu
//   alu_res              combinational alu result
//   rsp_valid/rsp_ready  per-requester response handshake (rsp_valid is one-hot or zero)
//   rsp_res/rsp_id       buffered result and the index of the requester that owns it
module alu_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic            [NUM_REQ-1:0]       req_valid,
    output logic            [NUM_REQ-1:0]       req_ready,
    input  logic            [NUM_REQ-1:0][31:0] req_a,
    input  logic            [NUM_REQ-1:0][31:0] req_b,
    input  alu_pkg::alu_op_t [NUM_REQ-1:0]      req_op,
    output logic            [31:0]              alu_a,
    output logic            [31:0]              alu_b,
    output alu_pkg::alu_op_t                    alu_op,
    input  logic            [31:0]              alu_res,
    output logic            [NUM_REQ-1:0]       rsp_valid,
    input  logic            [NUM_REQ-1:0]       rsp_ready,
    output logic            [31:0]              rsp_res,
    output logic            [ID_W-1:0]          rsp_id
);

    logic            full_q;
    logic [31:0]     res_q;
    logic [ID_W-1:0] id_q;
    logic [ID_W-1:0] prio_q;

    logic            gnt_any;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W-1:0] scan;
    logic            drain;
    logic            can_acc;
    logic            accept;

    // Search starting at prio_q and wrapping modulo NUM_REQ; the first valid requester wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan = ID_W'((32'(prio_q) + k) % NUM_REQ);
            if (!gnt_any && req_valid[scan]) begin
                gnt_any = 1'b1;
                gnt_idx = scan;
            end
        end
    end

    assign drain   = full_q && rsp_ready[id_q];
    // A draining buffer can take a new result in the same cycle.
    assign can_acc = !full_q || drain;
    assign accept  = gnt_any && can_acc && !rst;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Alu is driven by the grant even when stalled, so alu_res is ready the moment it is taken.
    always_comb begin
        alu_a  = 32'd0;
        alu_b  = 32'd0;
        alu_op = alu_pkg::AluAdd;
        if (gnt_any) begin
            alu_a  = req_a[gnt_idx];
            alu_b  = req_b[gnt_idx];
            alu_op = req_op[gnt_idx];
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (full_q) begin
            rsp_valid[id_q] = 1'b1;
        end
    end

    assign rsp_res = res_q;
    assign rsp_id  = id_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            res_q  <= 32'd0;
            id_q   <= '0;
            prio_q <= '0;
        end else if (accept) begin
            full_q <= 1'b1;
            res_q  <= alu_res;
            id_q   <= gnt_idx;
            prio_q <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end else if (drain) begin
            full_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with three requesters and a behavioural alu.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int NUM = 3;
    localparam int IDW = 2;

    logic                      clk;
    logic                      rst;
    logic    [NUM-1:0]         req_valid;
    logic    [NUM-1:0]         req_ready;
    logic    [NUM-1:0][31:0]   req_a;
    logic    [NUM-1:0][31:0]   req_b;
    alu_op_t [NUM-1:0]         req_op;
    logic    [31:0]            alu_a;
    logic    [31:0]            alu_b;
    alu_op_t                   alu_op;
    logic    [31:0]            alu_res;
    logic    [NUM-1:0]         rsp_valid;
    logic    [NUM-1:0]         rsp_ready;
    logic    [31:0]            rsp_res;
    logic    [IDW-1:0]         rsp_id;

    int n_checks;
    int n_pass;

    // Reference model state
    bit          m_full;
    logic [31:0] m_res;
    int          m_id;
    int          m_prio;
    int          last_grant;

    alu_arbiter #(
        .NUM_REQ(NUM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_op   (req_op),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_res  (alu_res),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_res  (rsp_res),
        .rsp_id   (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(logic [31:0] a, logic [31:0] b, alu_op_t op);
        case (op)
            AluAdd:  return a + b;
            AluSub:  return a - b;
            AluSll:  return a << b[4:0];
            AluSlt:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            AluSltu: return (a < b) ? 32'd1 : 32'd0;
            AluXor:  return a ^ b;
            AluSrl:  return a >> b[4:0];
            AluSra:  return 32'($signed(a) >>> b[4:0]);
            AluOr:   return a | b;
            AluAnd:  return a & b;
            default: return 32'd0;
        endcase
    endfunction

    always_comb alu_res = alu_model(alu_a, alu_b, alu_op);

    // Valid requester nearest to prio in circular distance, -1 when none.
    function automatic int model_grant(logic [NUM-1:0] v, int prio);
        int best;
        int bestd;
        best  = -1;
        bestd = NUM;
        for (int i = 0; i < NUM; i++) begin
            if (v[i] && (((i - prio + NUM) % NUM) < bestd)) begin
                bestd = (i - prio + NUM) % NUM;
                best  = i;
            end
        end
        return best;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_req(int i, logic v, alu_op_t op, logic [31:0] a, logic [31:0] b);
        req_valid[i] = v;
        req_op[i]    = op;
        req_a[i]     = a;
        req_b[i]     = b;
    endtask

    // Check one cycle at the falling edge, then advance the model over the rising edge.
    task automatic cycle();
        int             g;
        int             gi;
        bit             acc;
        logic [NUM-1:0] er;
        logic [31:0]    nres;
        @(negedge clk);
        g   = model_grant(req_valid, m_prio);
        gi  = (g < 0) ? 0 : g;
        acc = (g >= 0) && !rst && (!m_full || rsp_ready[m_id]);
        er  = '0;
        if (acc) er[gi] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("alu_a", alu_a, (g >= 0) ? req_a[gi] : 32'd0);
        chk("alu_b", alu_b, (g >= 0) ? req_b[gi] : 32'd0);
        chk("alu_op", 32'(alu_op), (g >= 0) ? 32'(req_op[gi]) : 32'(AluAdd));
        chk("rsp_valid", 32'(rsp_valid), m_full ? (32'd1 << m_id) : 32'd0);
        chk("rsp_res", rsp_res, m_res);
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        nres = alu_model(req_a[gi], req_b[gi], req_op[gi]);
        @(posedge clk);
        last_grant = acc ? g : -1;
        if (rst) begin
            m_full = 0;
            m_res  = 32'd0;
            m_id   = 0;
            m_prio = 0;
        end else if (acc) begin
            m_full = 1;
            m_res  = nres;
            m_id   = g;
            m_prio = (g + 1) % NUM;
        end else if (m_full && rsp_ready[m_id]) begin
            m_full = 0;
        end
        #1;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        m_full     = 0;
        m_res      = 32'd0;
        m_id       = 0;
        m_prio     = 0;
        last_grant = -1;
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        for (int i = 0; i < NUM; i++) req_op[i] = AluAdd;
        rsp_ready  = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset cycle with a pending request: nothing may be accepted.
        set_req(0, 1'b1, AluAdd, 32'd5, 32'd7);
        cycle();
        rst = 1'b0;

        // Single request
        rsp_ready = 3'b111;
        cycle();
        chk("single_grant", 32'(last_grant), 32'd0);
        set_req(0, 1'b0, AluAdd, 32'd0, 32'd0);
        cycle();
        chk("single_res", rsp_res, 32'd12);

        // Contention: two requesters held valid, one accept per cycle
        set_req(0, 1'b1, AluSub, 32'd10, 32'd3);
        set_req(1, 1'b1, AluSra, 32'h8000_0000, 32'd4);
        repeat (6) cycle();
        chk("cont_res1", (rsp_id == 2'd1) ? rsp_res : 32'hF800_0000, 32'hF800_0000);
        set_req(0, 1'b0, AluAdd, 32'd0, 32'd0);
        set_req(1, 1'b0, AluAdd, 32'd0, 32'd0);
        cycle();

        // Backpressure on requester 1 while requester 0 waits
        set_req(1, 1'b1, AluSlt, 32'hFFFF_FFFF, 32'd1);
        cycle();
        set_req(1, 1'b0, AluAdd, 32'd0, 32'd0);
        set_req(0, 1'b1, AluAdd, 32'd100, 32'd23);
        rsp_ready[1] = 1'b0;
        repeat (3) cycle();
        chk("bp_hold", rsp_res, 32'd1);
        rsp_ready[1] = 1'b1;
        cycle();
        chk("bp_release", 32'(last_grant), 32'd0);
        set_req(0, 1'b0, AluAdd, 32'd0, 32'd0);
        cycle();

        // Rotation with wrap-around, then skip a dropped requester
        set_req(0, 1'b1, AluXor, 32'h0F0F_0F0F, 32'h00FF_00FF);
        set_req(1, 1'b1, AluOr, 32'h1200_0034, 32'h0056_7800);
        set_req(2, 1'b1, AluSltu, 32'd3, 32'hFFFF_FFFE);
        repeat (5) cycle();
        set_req(1, 1'b0, AluAdd, 32'd0, 32'd0);
        repeat (4) cycle();
        set_req(0, 1'b0, AluAdd, 32'd0, 32'd0);
        set_req(2, 1'b0, AluAdd, 32'd0, 32'd0);
        cycle();

        // Reset with an undrained response and a pending request
        set_req(0, 1'b1, AluAdd, 32'd1, 32'd2);
        set_req(2, 1'b1, AluAnd, 32'hFFFF_0000, 32'h1234_5678);
        rsp_ready = 3'b000;
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        chk("post_rst_grant", 32'(last_grant), 32'd0);
        rsp_ready = 3'b111;
        set_req(0, 1'b0, AluAdd, 32'd0, 32'd0);
        set_req(2, 1'b0, AluAdd, 32'd0, 32'd0);
        cycle();

        // Idle: defaults on the alu drive, pointer must not move
        repeat (10) cycle();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM; i++) begin
                set_req(i, 1'($urandom_range(0, 1)), alu_op_t'($urandom_range(0, 9)),
                        $urandom(), $urandom());
            end
            for (int i = 0; i < NUM; i++) rsp_ready[i] = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 49) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
